// File: rtl/cavlc_coeff_buffer_if.sv
// ----------------------------------------------------------------------------
// cavlc_coeff_buffer_if
//   Bundles the coefficient input side (from the flow-control gate) and the
//   CAVLC replay side (to the encoder) of cavlc_coeff_buffer.
//
//   master : the environment -- drives VALIDI/DATAI and READY.
//   slave  : the buffer      -- drives BUSY/OVERFLOW and the replay outputs.
//
//   VALIDI/DATAI   zigzag-ordered coefficient beats
//   BUSY/OVERFLOW  write bank full / sticky dropped-beat flag
//   VALIDO/READY   replay handshake
//   COEFF/RUN_BEFORE/LAST/ZERO_BLK  replay beat
//   TOTAL_COEFF/TRAILING_ONES/TOTAL_ZEROS  block header
// ----------------------------------------------------------------------------
interface cavlc_coeff_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int BLK_SIZE   = 16
);
    localparam int CW = $clog2(BLK_SIZE + 1);

    logic                         VALIDI;
    logic signed [DATA_WIDTH-1:0] DATAI;
    logic                         BUSY;
    logic                         OVERFLOW;
    logic                         VALIDO;
    logic                         READY;
    logic signed [DATA_WIDTH-1:0] COEFF;
    logic [CW-1:0]                RUN_BEFORE;
    logic                         LAST;
    logic                         ZERO_BLK;
    logic [CW-1:0]                TOTAL_COEFF;
    logic [1:0]                   TRAILING_ONES;
    logic [CW-1:0]                TOTAL_ZEROS;

    modport master (
        output VALIDI, DATAI, READY,
        input  BUSY, OVERFLOW, VALIDO, COEFF, RUN_BEFORE, LAST, ZERO_BLK,
               TOTAL_COEFF, TRAILING_ONES, TOTAL_ZEROS
    );

    modport slave (
        input  VALIDI, DATAI, READY,
        output BUSY, OVERFLOW, VALIDO, COEFF, RUN_BEFORE, LAST, ZERO_BLK,
               TOTAL_COEFF, TRAILING_ONES, TOTAL_ZEROS
    );
endinterface

// File: rtl/cavlc_coeff_buffer.sv
// ----------------------------------------------------------------------------
// cavlc_coeff_buffer
//   Collects one 4x4 block of zigzag-ordered coefficients at a time into a
//   two-bank ping-pong buffer, computes the CAVLC header (TotalCoeff,
//   TrailingOnes, TotalZeros) while the block streams in, then replays the
//   nonzero levels highest-index first with their run_before.
//
//   clk    clock
//   RESET  synchronous, active-high; discards any partial block
//   bus    cavlc_coeff_buffer_if.slave (input beats, replay handshake,
//          header fields, BUSY / OVERFLOW)
// ----------------------------------------------------------------------------
module cavlc_coeff_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BLK_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  RESET,
    cavlc_coeff_buffer_if.slave   bus
);
    localparam int CW = $clog2(BLK_SIZE + 1);
    localparam int IW = $clog2(BLK_SIZE);

    localparam logic signed [DATA_WIDTH-1:0] P_ONE = DATA_WIDTH'(1);
    localparam logic signed [DATA_WIDTH-1:0] M_ONE = '1;

    typedef enum logic [1:0] {R_IDLE, R_SCAN, R_PRESENT, R_RELEASE} rd_state_t;

    // ------------------------------------------------------------------
    // Storage: coefficient banks plus per-bank header stats and a
    // nonzero map (the map lets run_before be found without re-reading
    // the coefficient array).
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] mem [2][BLK_SIZE];
    logic [1:0]                   full_q;
    logic [1:0][CW-1:0]           tc_q;
    logic [1:0][1:0]              t1_q;
    logic [1:0][IW-1:0]           last_q;
    logic [1:0][CW-1:0]           tz_q;
    logic [1:0][BLK_SIZE-1:0]     mask_q;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic          overflow_q;

    logic                busy, accept, blk_end, is_nz, is_one;
    logic [CW-1:0]       b_tc, n_tc, n_tz;
    logic [1:0]          b_t1, n_t1;
    logic [IW-1:0]       b_last, n_last;
    logic [BLK_SIZE-1:0] b_mask, n_mask;

    logic rel;  // read side frees rd_bank this cycle
    logic rd_bank;

    assign busy = full_q[wr_bank];

    always_comb begin
        accept  = bus.VALIDI && !busy;
        blk_end = (wr_idx == IW'(BLK_SIZE - 1));
        is_nz   = (bus.DATAI != '0);
        is_one  = (bus.DATAI == P_ONE) || (bus.DATAI == M_ONE);

        // Stats start from zero on the first beat of a block, so stale
        // values from the previous block in this bank never leak in.
        b_tc   = (wr_idx == '0) ? '0 : tc_q[wr_bank];
        b_t1   = (wr_idx == '0) ? '0 : t1_q[wr_bank];
        b_last = (wr_idx == '0) ? '0 : last_q[wr_bank];
        b_mask = (wr_idx == '0) ? '0 : mask_q[wr_bank];

        n_tc   = b_tc + CW'(is_nz);
        n_last = is_nz ? wr_idx : b_last;
        n_t1   = b_t1;
        if (is_nz) begin
            if (is_one) n_t1 = (b_t1 == 2'd3) ? 2'd3 : b_t1 + 2'd1;
            else        n_t1 = 2'd0;
        end
        n_mask         = b_mask;
        n_mask[wr_idx] = is_nz;

        // Zeros below the highest nonzero; only meaningful on the final beat.
        n_tz = (n_tc == '0) ? '0 : CW'(n_last) + CW'(1) - n_tc;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wr_idx] <= bus.DATAI;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            overflow_q <= 1'b0;
            full_q     <= '0;
            tc_q       <= '0;
            t1_q       <= '0;
            last_q     <= '0;
            tz_q       <= '0;
            mask_q     <= '0;
        end else begin
            if (bus.VALIDI && busy) overflow_q <= 1'b1;

            if (accept) begin
                tc_q[wr_bank]   <= n_tc;
                t1_q[wr_bank]   <= n_t1;
                last_q[wr_bank] <= n_last;
                mask_q[wr_bank] <= n_mask;
                if (blk_end) begin
                    tz_q[wr_bank]   <= n_tz;
                    full_q[wr_bank] <= 1'b1;
                    wr_idx          <= '0;
                    wr_bank         <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end

            // The writer only ever targets a non-full bank and the reader
            // only releases a full one, so these never hit the same bit.
            if (rel) full_q[rd_bank] <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t     state_q, state_d;
    logic [IW-1:0] ptr;
    logic [CW-1:0] beat_cnt;
    logic          zero_blk_q;
    logic [CW-1:0] hdr_tc, hdr_tz;
    logic [1:0]    hdr_t1;

    logic          valido, last_beat;
    logic [CW-1:0] rb;

    always_ff @(posedge clk) begin
        if (RESET) state_q <= R_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        valido    = 1'b0;
        rel       = 1'b0;
        last_beat = zero_blk_q || (beat_cnt == hdr_tc - CW'(1));
        case (state_q)
            // The entry at last_nz is nonzero by construction, so there is
            // nothing to scan for the first beat: present it directly.
            R_IDLE:    if (full_q[rd_bank]) state_d = R_PRESENT;
            R_SCAN:    if (mask_q[rd_bank][ptr]) state_d = R_PRESENT;
            R_PRESENT: begin
                valido = 1'b1;
                if (bus.READY) state_d = last_beat ? R_RELEASE : R_SCAN;
            end
            R_RELEASE: begin
                rel     = 1'b1;
                state_d = R_IDLE;
            end
            default:   state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            rd_bank    <= 1'b0;
            ptr        <= '0;
            beat_cnt   <= '0;
            zero_blk_q <= 1'b0;
            hdr_tc     <= '0;
            hdr_t1     <= '0;
            hdr_tz     <= '0;
        end else begin
            case (state_q)
                R_IDLE: if (full_q[rd_bank]) begin
                    hdr_tc     <= tc_q[rd_bank];
                    hdr_t1     <= t1_q[rd_bank];
                    hdr_tz     <= tz_q[rd_bank];
                    zero_blk_q <= (tc_q[rd_bank] == '0);
                    ptr        <= last_q[rd_bank];
                    beat_cnt   <= '0;
                end
                R_SCAN: if (!mask_q[rd_bank][ptr]) ptr <= ptr - IW'(1);
                R_PRESENT: if (bus.READY && !last_beat) begin
                    ptr      <= ptr - IW'(1);
                    beat_cnt <= beat_cnt + CW'(1);
                end
                R_RELEASE: begin
                    rd_bank    <= ~rd_bank;
                    zero_blk_q <= 1'b0;
                    hdr_tc     <= '0;
                    hdr_t1     <= '0;
                    hdr_tz     <= '0;
                end
                default: ;
            endcase
        end
    end

    // run_before = zeros strictly between ptr and the next lower nonzero,
    // or ptr itself when nothing nonzero lies below it.
    always_comb begin
        rb = CW'(ptr);
        for (int j = 0; j < BLK_SIZE; j++) begin
            if ((IW'(j) < ptr) && mask_q[rd_bank][j])
                rb = CW'(ptr) - CW'(j) - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: beat fields are forced to zero outside R_PRESENT.
    // ------------------------------------------------------------------
    assign bus.BUSY          = busy;
    assign bus.OVERFLOW      = overflow_q;
    assign bus.VALIDO        = valido;
    assign bus.COEFF         = (valido && !zero_blk_q) ? mem[rd_bank][ptr] : '0;
    assign bus.RUN_BEFORE    = (valido && !zero_blk_q) ? rb : '0;
    assign bus.LAST          = valido && last_beat;
    assign bus.ZERO_BLK      = valido && zero_blk_q;
    assign bus.TOTAL_COEFF   = hdr_tc;
    assign bus.TRAILING_ONES = hdr_t1;
    assign bus.TOTAL_ZEROS   = hdr_tz;

endmodule

// File: tb/tb_cavlc_coeff_buffer.sv
// ----------------------------------------------------------------------------
// tb_cavlc_coeff_buffer
//   Directed bench for cavlc_coeff_buffer: hand-computed headers and replay
//   beats for several blocks, ping-pong overflow, READY back-pressure and
//   reset in the middle of a readout and a write.
// ----------------------------------------------------------------------------
module tb_cavlc_coeff_buffer;
    logic clk = 1'b0;
    logic RESET;

    always #5 clk = ~clk;

    cavlc_coeff_buffer_if #(.DATA_WIDTH(16), .BLK_SIZE(16)) bus ();

    cavlc_coeff_buffer #(.DATA_WIDTH(16), .BLK_SIZE(16)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int blk [16];
    int exp_c [3];
    int exp_r [3];
    int exp_l [3];
    int k;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_block();
        for (int i = 0; i < 16; i++) begin
            bus.VALIDI = 1'b1;
            bus.DATAI  = 16'(blk[i]);
            tick();
        end
        bus.VALIDI = 1'b0;
        bus.DATAI  = '0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.VALIDO && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, bus.VALIDO, 1);
    endtask

    // READY must already be 1: the beat is accepted on the following edge.
    task automatic get_beat(input string tag, input int c, input int r, input int l);
        wait_valid(tag);
        check({tag, ".coeff"}, bus.COEFF, c);
        check({tag, ".run"},   bus.RUN_BEFORE, r);
        check({tag, ".last"},  bus.LAST, l);
        tick();
    endtask

    task automatic check_hdr(input string tag, input int tc, input int t1, input int tz);
        check({tag, ".tc"}, bus.TOTAL_COEFF, tc);
        check({tag, ".t1"}, bus.TRAILING_ONES, t1);
        check({tag, ".tz"}, bus.TOTAL_ZEROS, tz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET      = 1'b1;
        bus.VALIDI = 1'b0;
        bus.DATAI  = '0;
        bus.READY  = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst.valido",   bus.VALIDO, 0);
        check("rst.busy",     bus.BUSY, 0);
        check("rst.overflow", bus.OVERFLOW, 0);
        check("rst.coeff",    bus.COEFF, 0);
        check("rst.last",     bus.LAST, 0);
        check_hdr("rst", 0, 0, 0);
        RESET = 1'b0;
        tick();

        // ---- block 1: 0,3,0,1,-1,-1,0,1 ----
        bus.READY = 1'b1;
        blk = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        send_block();                                  // cycle T+1
        check("b1.T+1.valid", bus.VALIDO, 0);
        tick();                                        // cycle T+2
        check("b1.T+2.valid", bus.VALIDO, 1);
        check_hdr("b1", 5, 3, 3);
        check("b1.b1.coeff", bus.COEFF, 1);
        check("b1.b1.run",   bus.RUN_BEFORE, 1);
        check("b1.b1.last",  bus.LAST, 0);
        tick();                                        // H+1: scan idx6
        check("b1.H+1.valid", bus.VALIDO, 0);
        tick();                                        // H+2: scan idx5
        check("b1.H+2.valid", bus.VALIDO, 0);
        tick();                                        // H+3 = H+2+1
        check("b1.H+3.valid", bus.VALIDO, 1);
        get_beat("b1.b2", -1, 0, 0);
        get_beat("b1.b3", -1, 0, 0);
        get_beat("b1.b4",  1, 1, 0);
        get_beat("b1.b5",  3, 1, 1);
        check("b1.release.valid", bus.VALIDO, 0);
        tick();
        check("b1.idle.tc", bus.TOTAL_COEFF, 0);

        // ---- block 2: all zeros ----
        blk = '{default: 0};
        send_block();
        check("b2.T+1.valid", bus.VALIDO, 0);
        tick();
        check("b2.T+2.valid", bus.VALIDO, 1);
        check("b2.zero_blk",  bus.ZERO_BLK, 1);
        check("b2.last",      bus.LAST, 1);
        check("b2.coeff",     bus.COEFF, 0);
        check_hdr("b2", 0, 0, 0);
        tick();
        tick();
        check("b2.after.valid", bus.VALIDO, 0);

        // ---- block 3: only idx15 = -2 ----
        blk = '{default: 0};
        blk[15] = -2;
        send_block();
        tick();
        check("b3.T+2.valid", bus.VALIDO, 1);
        check_hdr("b3", 1, 0, 15);
        get_beat("b3.b1", -2, 15, 1);
        tick();
        tick();

        // ---- ping-pong fill with READY=0, third block dropped ----
        bus.READY = 1'b0;
        blk = '{default: 0};
        blk[0] = 5; blk[2] = -1;                       // TC2 T1 1 TZ1
        send_block();
        blk = '{default: 0};
        blk[1] = 1; blk[3] = 1; blk[4] = 1; blk[5] = 1;  // TC4 T1 3 TZ2
        send_block();
        check("ovf.busy",      bus.BUSY, 1);
        check("ovf.overflow0", bus.OVERFLOW, 0);
        blk = '{default: 7};
        send_block();
        check("ovf.overflow1", bus.OVERFLOW, 1);
        check("ovf.busy_held", bus.BUSY, 1);
        check("ovf.held.valid", bus.VALIDO, 1);
        check("ovf.held.coeff", bus.COEFF, -1);
        check_hdr("ovfA", 2, 1, 1);
        bus.READY = 1'b1;
        get_beat("ovfA.b1", -1, 1, 0);
        get_beat("ovfA.b2",  5, 0, 1);
        wait_valid("ovfB.hdr");
        check_hdr("ovfB", 4, 3, 2);
        get_beat("ovfB.b1", 1, 0, 0);
        get_beat("ovfB.b2", 1, 0, 0);
        get_beat("ovfB.b3", 1, 1, 0);
        get_beat("ovfB.b4", 1, 1, 1);
        tick();
        tick();
        check("ovf.drained.valid", bus.VALIDO, 0);
        check("ovf.drained.busy",  bus.BUSY, 0);

        // ---- READY toggling every cycle ----
        blk = '{default: 0};
        blk[0] = 2; blk[2] = -3; blk[6] = 1;           // TC3 T1 1 TZ4
        exp_c = '{1, -3, 2};
        exp_r = '{3, 1, 0};
        exp_l = '{0, 0, 1};
        send_block();
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
            bus.READY = (cyc % 2 == 1);
            if (bus.VALIDO) begin
                check("tog.coeff", bus.COEFF, exp_c[k]);
                check("tog.run",   bus.RUN_BEFORE, exp_r[k]);
                check("tog.last",  bus.LAST, exp_l[k]);
                check_hdr("tog", 3, 1, 4);
                if (bus.READY) k++;
            end
            tick();
        end
        check("tog.beats", k, 3);
        check("tog.no_dup.valid", bus.VALIDO, 0);
        tick();
        tick();

        // ---- reset mid-readout and mid-write ----
        bus.READY = 1'b0;
        blk = '{default: 0};
        blk[3] = 2;
        send_block();
        tick();
        check("rst2.pre.valid", bus.VALIDO, 1);
        for (int i = 0; i < 5; i++) begin
            bus.VALIDI = 1'b1;
            bus.DATAI  = 16'(i + 9);
            tick();
        end
        bus.VALIDI = 1'b0;
        check("rst2.pre.overflow", bus.OVERFLOW, 1);
        RESET = 1'b1;
        tick();
        check("rst2.valid",    bus.VALIDO, 0);
        check("rst2.overflow", bus.OVERFLOW, 0);
        check("rst2.busy",     bus.BUSY, 0);
        check("rst2.coeff",    bus.COEFF, 0);
        check_hdr("rst2", 0, 0, 0);
        RESET = 1'b0;
        bus.READY = 1'b1;
        tick();
        tick();
        check("rst2.idle.valid", bus.VALIDO, 0);
        blk = '{default: 0};
        blk[0] = 1; blk[15] = 4;                       // TC2 T1 0 TZ14
        send_block();
        tick();
        check("post.T+2.valid", bus.VALIDO, 1);
        check_hdr("post", 2, 0, 14);
        get_beat("post.b1", 4, 14, 0);
        get_beat("post.b2", 1, 0, 1);
        check("post.release.valid", bus.VALIDO, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
